pe_input_feed_scheduler: RTL and testbench
==========================================

Name: pe_input_feed_scheduler

Overview:
- Sequences one feature-map tile into Input_pre_data_module on the input-side clock.
- Reads pixels from a synchronous-read feature-map RAM and inserts border padding on the fly.
- Emits the padded raster as i_data_din / i_data_din_vld, then waits for the pre-data module's dout_vld before reporting done.

Parameters:
- DATA_W, 8, pixel width.
- DIM_W, 6, width of the height/width config fields (max dimension 63).
- ADDR_W, 12, RAM address width.
- PAD_W, 2, width of the pad-per-side field (0..3).

Ports:
- din_clk  in  1  clock (input-side clock of the PE pipeline).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- abort  in  1  synchronous cancel.
- en  in  1  pause when low.
- cfg_width  in  DIM_W  unpadded tile width W.
- cfg_height  in  DIM_W  unpadded tile height H.
- cfg_pad  in  PAD_W  padding per side P.
- cfg_pad_value  in  DATA_W  byte emitted at pad positions.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_rd_data  in  DATA_W  RAM data, valid the cycle after mem_rd_en.
- o_data_din  out  DATA_W  to i_data_din.
- o_data_din_vld  out  1  to i_data_din_vld.
- pe_dout_vld  in  1  from the pre-data module's dout_vld.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: async, active-low. Clock: single clock, din_clk.
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, RUN, DRAIN, WAIT_PE, DONE.
- IDLE:
  - start with W≠0 and H≠0: latch cfg_*, row=col=0, base=0, go to RUN, busy←1.
  - start with W=0 or H=0: err pulses 1 cycle, stay IDLE.
- Padded dimensions: Wp=W+2P, Hp=H+2P. Positions visited in raster order: col fastest, row 0..Hp-1.
- Pad position: row<P, row≥H+P, col<P, or col≥W+P.
- RUN, with en=1, one position per cycle:
  - Non-pad: mem_rd_en=1 (combinational), mem_addr=(row-P)*W+(col-P). Computed with a row-base accumulator, no multiplier; truncated to ADDR_W.
  - Pad: mem_rd_en=0.
- RUN, with en=0: counters hold, mem_rd_en=0. Already-issued positions still complete.
- Pipeline stage B (registered): vld_b, pad_b.
- Output register: o_data_din ← pad_b ? latched pad value : mem_rd_data; o_data_din_vld ← vld_b.
- Latency: o_data_din_vld rises exactly 2 clocks after busy rises. A pause of N cycles gives an N-cycle vld gap, delayed by 2 cycles.
- After position (Hp-1,Wp-1) is issued: RUN→DRAIN, held 2 cycles, then WAIT_PE.
- Total valid bytes per frame: exactly Wp*Hp.
- WAIT_PE: exit on the first pe_dout_vld=1 → DONE. pe_dout_vld in other states is ignored.
- DONE: done=1 for 1 cycle, busy←0, next state IDLE.
- A start in the DONE cycle is ignored. Start while busy is ignored with no err.
- abort=1 in any non-IDLE state:
  - Next edge: IDLE, busy=0, vld_b=0, o_data_din_vld=0; no done.
  - In-flight bytes are discarded.
  - abort has priority over start and over pe_dout_vld.
- Async reset mid-frame: immediate return to reset values. A new start is required afterwards.
- Config inputs changing during busy have no effect.

Test Plan:
- W=3,H=3,P=1, pad value 0x81, RAM[i]=0x10+i, en=1:
  - 25 consecutive vld bytes, vld starting 2 clocks after busy.
  - Sequence: 81×6, 10,11,12, 81,81, 13,14,15, 81,81, 16,17,18, 81×6.
  - 9 reads at addresses 0..8.
  - Pulse pe_dout_vld 5 cycles later → done exactly one cycle later, busy drops.
- W=4,H=2,P=0: 8 bytes = RAM[0..7], no pad bytes, mem_rd_en high for 8 consecutive cycles.
- Same as scenario 1 with en low for 3 cycles after the 7th position:
  - Byte sequence unchanged, single 3-cycle vld gap.
  - Still 25 valid bytes.
- Abort after the 10th vld byte:
  - Next cycle vld=0, busy=0, no done.
  - A following start replays the full 25-byte frame from the beginning.
- Start with cfg_width=0 → err pulse, busy stays 0. Second start while busy → ignored, frame unaffected.
- rst_n low mid-RUN → all outputs 0 immediately. After release, idle until a new start.

Source files
------------

// File: rtl/pe_input_feed_scheduler_if.sv
// Bus bundle between the input-feed scheduler, the feature-map RAM and the
// Input_pre_data_module.
//   master (scheduler): drives mem_rd_en/mem_addr, o_data_din/o_data_din_vld;
//                       receives mem_rd_data and pe_dout_vld.
//   slave  (RAM + PE) : the mirror image.
interface pe_input_feed_scheduler_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] o_data_din;
    logic              o_data_din_vld;
    logic              pe_dout_vld;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output o_data_din,
        output o_data_din_vld,
        input  pe_dout_vld
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  o_data_din,
        input  o_data_din_vld,
        output pe_dout_vld
    );
endinterface

// File: rtl/pe_input_feed_scheduler.sv
// Input feed scheduler for one feature-map tile.
//
// Walks the padded tile (W+2P) x (H+2P) in raster order, one position per
// enabled cycle. Interior positions read the synchronous feature-map RAM,
// border positions emit the latched pad byte. Bytes reach o_data_din two
// clocks after the position is issued. After the last position and a
// two-cycle drain the block waits for the pre-data module's dout_vld, then
// pulses done.
//
// Ports:
//   din_clk, rst_n      clock, asynchronous active-low reset
//   start               frame request, sampled only while idle
//   abort               synchronous cancel of a running frame
//   en                  pause issuing positions while low
//   cfg_width/height    unpadded tile dimensions (must be non-zero)
//   cfg_pad             pad width per side
//   cfg_pad_value       byte emitted at pad positions
//   bus (master)        RAM read port, pixel stream out, pe_dout_vld in
//   busy                frame in progress
//   done                one-cycle completion pulse
//   err                 one-cycle pulse on a start with zero width/height
module pe_input_feed_scheduler #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIM_W  = 6,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned PAD_W  = 2
) (
    input  logic                       din_clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       en,
    input  logic [DIM_W-1:0]           cfg_width,
    input  logic [DIM_W-1:0]           cfg_height,
    input  logic [PAD_W-1:0]           cfg_pad,
    input  logic [DATA_W-1:0]          cfg_pad_value,
    pe_input_feed_scheduler_if.master  bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    // Two extra bits so W+2P and H+2P never overflow the position counters.
    localparam int unsigned CNT_W = DIM_W + 2;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRun    = 3'd1;
    localparam logic [2:0] StDrain  = 3'd2;
    localparam logic [2:0] StWaitPe = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              drain_q, drain_d;

    logic [DIM_W-1:0]  w_q, w_d;
    logic [DIM_W-1:0]  h_q, h_d;
    logic [PAD_W-1:0]  p_q, p_d;
    logic [DATA_W-1:0] pv_q, pv_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              vld_b_q, vld_b_d;
    logic              pad_b_q, pad_b_d;
    logic              o_vld_q, o_vld_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;

    logic [CNT_W-1:0]  p_ext, w_ext, h_ext;
    logic [CNT_W-1:0]  w_end, h_end;
    logic [CNT_W-1:0]  wp, hp;
    logic              row_is_data, col_is_data, is_pad;
    logic              last_col, last_row;
    logic              issue, rd_en, abort_now;
    logic [ADDR_W-1:0] addr;

    // ------------------------------------------------------------------
    // Position decode
    // ------------------------------------------------------------------
    always_comb begin
        p_ext = CNT_W'(p_q);
        w_ext = CNT_W'(w_q);
        h_ext = CNT_W'(h_q);
        w_end = w_ext + p_ext;
        h_end = h_ext + p_ext;
        wp    = w_end + p_ext;
        hp    = h_end + p_ext;

        row_is_data = (row_q >= p_ext) && (row_q < h_end);
        col_is_data = (col_q >= p_ext) && (col_q < w_end);
        is_pad      = !(row_is_data && col_is_data);

        last_col = (col_q == wp - CNT_W'(1));
        last_row = (row_q == hp - CNT_W'(1));

        issue     = (state_q == StRun) && en;
        rd_en     = issue && !is_pad;
        abort_now = abort && (state_q != StIdle);

        // base_q already holds (row-P)*W on data rows; col >= P here.
        addr = base_q + ADDR_W'(col_q - p_ext);
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = rd_en ? addr : '0;

    // ------------------------------------------------------------------
    // Control FSM and position counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        drain_d = drain_q;
        w_d     = w_q;
        h_d     = h_q;
        p_d     = p_q;
        pv_d    = pv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (cfg_width != '0 && cfg_height != '0) begin
                        state_d = StRun;
                        busy_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                        base_d  = '0;
                        drain_d = 1'b0;
                        w_d     = cfg_width;
                        h_d     = cfg_height;
                        p_d     = cfg_pad;
                        pv_d    = cfg_pad_value;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (en) begin
                    if (last_col) begin
                        col_d = '0;
                        // Leaving a data row: next data row starts W further on.
                        if (row_is_data) begin
                            base_d = base_q + ADDR_W'(w_q);
                        end
                        if (last_row) begin
                            state_d = StDrain;
                            drain_d = 1'b0;
                        end else begin
                            row_d = row_q + CNT_W'(1);
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                // Two cycles: lets the final position clear stage B and the
                // output register.
                if (drain_q) begin
                    state_d = StWaitPe;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            StWaitPe: begin
                if (pe_dout_vld_i()) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        if (abort_now) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    function automatic logic pe_dout_vld_i();
        return bus.pe_dout_vld;
    endfunction

    // ------------------------------------------------------------------
    // Data pipeline: stage B tags the issued position, output register
    // selects pad byte or RAM data (which lands the cycle after the read).
    // ------------------------------------------------------------------
    always_comb begin
        vld_b_d  = issue && !abort_now;
        pad_b_d  = is_pad;
        o_vld_d  = vld_b_q && !abort_now;
        o_data_d = o_data_q;
        if (vld_b_q) begin
            o_data_d = pad_b_q ? pv_q : bus.mem_rd_data;
        end
    end

    always_ff @(posedge din_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            row_q    <= '0;
            col_q    <= '0;
            base_q   <= '0;
            drain_q  <= 1'b0;
            w_q      <= '0;
            h_q      <= '0;
            p_q      <= '0;
            pv_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vld_b_q  <= 1'b0;
            pad_b_q  <= 1'b0;
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            base_q   <= base_d;
            drain_q  <= drain_d;
            w_q      <= w_d;
            h_q      <= h_d;
            p_q      <= p_d;
            pv_q     <= pv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            vld_b_q  <= vld_b_d;
            pad_b_q  <= pad_b_d;
            o_vld_q  <= o_vld_d;
            o_data_q <= o_data_d;
        end
    end

    assign bus.o_data_din     = o_data_q;
    assign bus.o_data_din_vld = o_vld_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule

// File: tb/tb_pe_input_feed_scheduler.sv
module tb_pe_input_feed_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, en;
    logic [5:0] cfg_width, cfg_height;
    logic [1:0] cfg_pad;
    logic [7:0] cfg_pad_value;
    logic       busy, done, err;

    always #5 clk = ~clk;

    pe_input_feed_scheduler_if #(.DATA_W(8), .ADDR_W(12)) bus ();

    pe_input_feed_scheduler #(
        .DATA_W(8), .DIM_W(6), .ADDR_W(12), .PAD_W(2)
    ) dut (
        .din_clk       (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .en            (en),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .cfg_pad       (cfg_pad),
        .cfg_pad_value (cfg_pad_value),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Synchronous-read RAM, RAM[i] = 0x10 + i
    logic [7:0] ram [0:4095];
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk) if (bus.mem_rd_en) ram_q <= ram[bus.mem_addr];
    assign bus.mem_rd_data = ram_q;

    int checks = 0;
    int errors = 0;

    // Monitor: samples 1 time unit after each rising edge
    int         cyc = 0;
    logic [7:0] got[$];
    int         vld_cyc[$];
    int         rd_addr[$];
    int         rd_cyc[$];
    int         busy_rise = -1;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic       busy_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.o_data_din_vld) begin
            got.push_back(bus.o_data_din);
            vld_cyc.push_back(cyc);
        end
        if (bus.mem_rd_en) begin
            rd_addr.push_back(int'(bus.mem_addr));
            rd_cyc.push_back(cyc);
        end
        if (busy && !busy_prev) busy_rise = cyc;
        busy_prev = busy;
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    logic [7:0] exp_frame [25];

    task automatic clear_mon();
        got.delete();
        vld_cyc.delete();
        rd_addr.delete();
        rd_cyc.delete();
        busy_rise = -1;
        done_cnt  = 0;
        err_cnt   = 0;
    endtask

    task automatic do_start(input int w, input int h, input int p, input int pv);
        cfg_width     = 6'(w);
        cfg_height    = 6'(h);
        cfg_pad       = 2'(p);
        cfg_pad_value = 8'(pv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (got.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Drives pe_dout_vld for one cycle; returns in the cycle done should show.
    task automatic pulse_pe();
        repeat (5) @(negedge clk);
        bus.pe_dout_vld = 1'b1;
        @(negedge clk);
        bus.pe_dout_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 7;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", bus.mem_rd_en); end
        if (bus.mem_addr !== 12'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.mem_addr); end
        if (bus.o_data_din !== 8'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.o_data_din); end
        if (bus.o_data_din_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", bus.o_data_din_vld); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", busy); end
    endtask

    task automatic test_padded_frame();
        bit ok;
        clear_mon();
        do_start(3, 3, 1, 8'h81);
        wait_bytes(25, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pad_timeout got %0d bytes want 25", got.size()); end
        repeat (3) @(negedge clk);
        checks++;
        if (got.size() !== 25) begin errors++; $display("FAIL pad_count got %0d want 25", got.size()); end
        for (int i = 0; i < 25 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_frame[i]) begin
                errors++; $display("FAIL pad_byte[%0d] got %h want %h", i, got[i], exp_frame[i]);
            end
        end
        if (got.size() == 25) begin
            checks += 2;
            if (vld_cyc[0] - busy_rise !== 2) begin
                errors++; $display("FAIL pad_latency got %0d want 2", vld_cyc[0] - busy_rise);
            end
            if (vld_cyc[24] - vld_cyc[0] !== 24) begin
                errors++; $display("FAIL pad_contiguous got span %0d want 24", vld_cyc[24] - vld_cyc[0]);
            end
        end
        checks++;
        if (rd_addr.size() !== 9) begin errors++; $display("FAIL pad_reads got %0d want 9", rd_addr.size()); end
        for (int i = 0; i < 9 && i < rd_addr.size(); i++) begin
            checks++;
            if (rd_addr[i] !== i) begin errors++; $display("FAIL pad_addr[%0d] got %0d want %0d", i, rd_addr[i], i); end
        end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL pad_early_done got %b want 0", done); end
        pulse_pe();
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL pad_done got %b want 1", done); end
        if (busy !== 1'b1) begin errors++; $display("FAIL pad_busy_at_done got %b want 1", busy); end
        @(negedge clk);
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL pad_done_pulse got %b want 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL pad_busy_drop got %b want 0", busy); end
        if (done_cnt !== 1) begin errors++; $display("FAIL pad_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_no_pad();
        bit ok;
        clear_mon();
        do_start(4, 2, 0, 8'hee);
        wait_bytes(8, ok);
        repeat (3) @(negedge clk);
        checks += 3;
        if (!ok || got.size() !== 8) begin errors++; $display("FAIL nopad_count got %0d want 8", got.size()); end
        if (rd_addr.size() !== 8) begin errors++; $display("FAIL nopad_reads got %0d want 8", rd_addr.size()); end
        if (rd_cyc.size() == 8 && rd_cyc[7] - rd_cyc[0] !== 7) begin
            errors++; $display("FAIL nopad_rd_consecutive got span %0d want 7", rd_cyc[7] - rd_cyc[0]);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL nopad_byte[%0d] got %h want %h", i, got[i], 8'(8'h10 + i));
            end
        end
        pulse_pe();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL nopad_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_pause();
        bit ok;
        clear_mon();
        do_start(3, 3, 1, 8'h81);
        repeat (7) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_bytes(25, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || got.size() !== 25) begin errors++; $display("FAIL pause_count got %0d want 25", got.size()); end
        for (int i = 0; i < 25 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_frame[i]) begin
                errors++; $display("FAIL pause_byte[%0d] got %h want %h", i, got[i], exp_frame[i]);
            end
        end
        if (got.size() == 25) begin
            checks += 3;
            if (vld_cyc[6] - vld_cyc[0] !== 6) begin
                errors++; $display("FAIL pause_head got span %0d want 6", vld_cyc[6] - vld_cyc[0]);
            end
            if (vld_cyc[7] - vld_cyc[6] !== 4) begin
                errors++; $display("FAIL pause_gap got %0d want 4", vld_cyc[7] - vld_cyc[6]);
            end
            if (vld_cyc[24] - vld_cyc[7] !== 17) begin
                errors++; $display("FAIL pause_tail got span %0d want 17", vld_cyc[24] - vld_cyc[7]);
            end
        end
        pulse_pe();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL pause_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok;
        clear_mon();
        do_start(3, 3, 1, 8'h81);
        wait_bytes(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_timeout got %0d bytes want 10", got.size()); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks += 2;
        if (bus.o_data_din_vld !== 1'b0) begin errors++; $display("FAIL abort_vld got %b want 0", bus.o_data_din_vld); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        bus.pe_dout_vld = 1'b1;
        repeat (10) @(negedge clk);
        bus.pe_dout_vld = 1'b0;
        checks += 2;
        if (got.size() !== 10) begin errors++; $display("FAIL abort_bytes got %0d want 10", got.size()); end
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        clear_mon();
        do_start(3, 3, 1, 8'h81);
        wait_bytes(25, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || got.size() !== 25) begin errors++; $display("FAIL replay_count got %0d want 25", got.size()); end
        for (int i = 0; i < 25 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_frame[i]) begin
                errors++; $display("FAIL replay_byte[%0d] got %h want %h", i, got[i], exp_frame[i]);
            end
        end
        pulse_pe();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL replay_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_err_and_busy_start();
        bit ok;
        clear_mon();
        do_start(0, 3, 1, 8'h81);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL err_w0 got %b want 1", err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL err_w0_busy got %b want 0", busy); end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", err); end
        do_start(3, 0, 1, 8'h81);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_h0 got %b want 1", err); end
        @(negedge clk);
        clear_mon();
        do_start(3, 3, 1, 8'h81);
        repeat (4) @(negedge clk);
        do_start(0, 5, 3, 8'h00);
        wait_bytes(25, ok);
        repeat (3) @(negedge clk);
        checks += 2;
        if (err_cnt !== 0) begin errors++; $display("FAIL busy_start_err got %0d want 0", err_cnt); end
        if (!ok || got.size() !== 25) begin errors++; $display("FAIL busy_start_count got %0d want 25", got.size()); end
        for (int i = 0; i < 25 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_frame[i]) begin
                errors++; $display("FAIL busy_start_byte[%0d] got %h want %h", i, got[i], exp_frame[i]);
            end
        end
        pulse_pe();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_start(3, 3, 1, 8'h81);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        if (bus.o_data_din_vld !== 1'b0) begin errors++; $display("FAIL areset_vld got %b want 0", bus.o_data_din_vld); end
        if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL areset_rd_en got %b want 0", bus.mem_rd_en); end
        if (bus.o_data_din !== 8'h0) begin errors++; $display("FAIL areset_data got %h want 0", bus.o_data_din); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle_busy got %b want 0", busy); end
        if (got.size() !== 0) begin errors++; $display("FAIL areset_idle_bytes got %0d want 0", got.size()); end
        if (rd_addr.size() !== 0) begin errors++; $display("FAIL areset_idle_reads got %0d want 0", rd_addr.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'(8'h10 + i);
        exp_frame = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81,
                      8'h81, 8'h10, 8'h11, 8'h12, 8'h81,
                      8'h81, 8'h13, 8'h14, 8'h15, 8'h81,
                      8'h81, 8'h16, 8'h17, 8'h18, 8'h81,
                      8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        start = 1'b0;
        abort = 1'b0;
        en    = 1'b1;
        cfg_width     = 6'd0;
        cfg_height    = 6'd0;
        cfg_pad       = 2'd0;
        cfg_pad_value = 8'h00;
        bus.pe_dout_vld = 1'b0;
        @(negedge clk);

        test_reset();
        test_padded_frame();
        test_no_pad();
        test_pause();
        test_abort();
        test_err_and_busy_start();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
